// File: rtl/tc3_mul_seq.sv
// tc3_mul_seq: sequential Toom-Cook-3 multiplier, 11b x 11b unsigned -> 22b.
// One shared signed multiplier forms a single evaluation-point product per
// cycle (5 EVAL cycles), then three INTERP cycles recombine the products.
// The product is held in OUT until the consumer takes it.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair present on U_IN/V_IN
//   in_ready   block accepts an operand pair this cycle (IDLE only)
//   U_IN,V_IN  unsigned operands
//   out_valid  Result holds a completed product
//   out_ready  consumer takes Result this cycle
//   Result     registered unsigned product
//   busy       high in every state except IDLE
//
// state  | meaning
// IDLE   | waiting for an operand pair
// EVAL   | one evaluation-point product per cycle, k = 0..4
// INTERP | three interpolation steps, k = 0..2; Result written on the last
// OUT    | Result presented, out_valid registered one cycle after entry
module tc3_mul_seq #(
  parameter int LIMB_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3*LIMB_W-2:0]          U_IN,
  input  logic [3*LIMB_W-2:0]          V_IN,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*(3*LIMB_W-1)-1:0]    Result,
  output logic                         busy
);

  localparam int OP_W  = 3*LIMB_W - 1;
  localparam int RES_W = 2*OP_W;

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_INTERP, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [LIMB_W-1:0]  u0_q, u0_d, u1_q, u1_d, v0_q, v0_d, v1_q, v1_d;
  logic [LIMB_W-2:0]  u2_q, u2_d, v2_q, v2_d;
  logic [14:0]        w0_q, w0_d, w1_q, w1_d, wm1_q, wm1_d, wm2_q, wm2_d;
  logic [14:0]        winf_q, winf_d;
  logic [17:0]        r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;

  logic [7:0]         ea, eb;
  logic [14:0]        prod;
  logic [17:0]        r1_n;

  function automatic logic [7:0] eval_pt(input logic [2:0] k,
                                         input logic [7:0] a0,
                                         input logic [7:0] a1,
                                         input logic [7:0] a2);
    case (k)
      3'd0:    eval_pt = a0;
      3'd1:    eval_pt = a0 + a1 + a2;
      3'd2:    eval_pt = a0 - a1 + a2;
      3'd3:    eval_pt = a0 - (a1 << 1) + (a2 << 2);
      default: eval_pt = a2;
    endcase
  endfunction

  function automatic logic [14:0] sx8(input logic [7:0] x);
    sx8 = {{7{x[7]}}, x};
  endfunction

  function automatic logic [17:0] sx15(input logic [14:0] x);
    sx15 = {{3{x[14]}}, x};
  endfunction

  function automatic logic [RES_W-1:0] sx18(input logic [17:0] x);
    sx18 = {{(RES_W-18){x[17]}}, x};
  endfunction

  function automatic logic [17:0] asr1(input logic [17:0] x);
    asr1 = {x[17], x[17:1]};
  endfunction

  // Exact division by 3: the dividend is always a multiple of 3, so
  // multiplying by the inverse of 3 modulo 2^18 yields the quotient.
  function automatic logic [17:0] div3(input logic [17:0] x);
    div3 = x * 18'h2AAAB;
  endfunction

  // Shared multiplier; evaluation values fit in 8b signed and their
  // products in 15b signed, so the low 15 bits of the product are exact.
  always_comb begin
    ea   = eval_pt(k_q, 8'(u0_q), 8'(u1_q), 8'(u2_q));
    eb   = eval_pt(k_q, 8'(v0_q), 8'(v1_q), 8'(v2_q));
    prod = sx8(ea) * sx8(eb);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    u0_d = u0_q; u1_d = u1_q; u2_d = u2_q;
    v0_d = v0_q; v1_d = v1_q; v2_d = v2_q;
    w0_d = w0_q; w1_d = w1_q; wm1_d = wm1_q; wm2_d = wm2_q; winf_d = winf_q;
    r1_d = r1_q; r2_d = r2_q; r3_d = r3_q;
    r1_n        = r1_q - r3_q;
    result_d    = result_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          u0_d = U_IN[LIMB_W-1:0];
          u1_d = U_IN[2*LIMB_W-1:LIMB_W];
          u2_d = U_IN[OP_W-1:2*LIMB_W];
          v0_d = V_IN[LIMB_W-1:0];
          v1_d = V_IN[2*LIMB_W-1:LIMB_W];
          v2_d = V_IN[OP_W-1:2*LIMB_W];
          k_d     = 3'd0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        case (k_q)
          3'd0:    w0_d   = prod;
          3'd1:    w1_d   = prod;
          3'd2:    wm1_d  = prod;
          3'd3:    wm2_d  = prod;
          default: winf_d = prod;
        endcase
        if (k_q == 3'd4) begin
          k_d     = 3'd0;
          state_d = S_INTERP;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_INTERP: begin
        case (k_q)
          3'd0: begin
            r3_d = div3(sx15(wm2_q) - sx15(w1_q));
            r1_d = asr1(sx15(w1_q) - sx15(wm1_q));
            r2_d = sx15(wm1_q) - sx15(w0_q);
            k_d  = 3'd1;
          end
          3'd1: begin
            r3_d = asr1(r2_q - r3_q) + (sx15(winf_q) << 1);
            r2_d = r2_q + r1_q - sx15(winf_q);
            k_d  = 3'd2;
          end
          default: begin
            r1_d     = r1_n;
            // Recombination at x = 2^LIMB_W; the true sum is non-negative
            // and below 2^RES_W, so modular arithmetic is exact.
            result_d = sx18(sx15(w0_q))
                     + (sx18(r1_n) << LIMB_W)
                     + (sx18(r2_q) << (2*LIMB_W))
                     + (sx18(r3_q) << (3*LIMB_W))
                     + (sx18(sx15(winf_q)) << (4*LIMB_W));
            k_d      = 3'd0;
            state_d  = S_OUT;
          end
        endcase
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      u0_q <= '0; u1_q <= '0; u2_q <= '0;
      v0_q <= '0; v1_q <= '0; v2_q <= '0;
      w0_q <= '0; w1_q <= '0; wm1_q <= '0; wm2_q <= '0; winf_q <= '0;
      r1_q <= '0; r2_q <= '0; r3_q <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      u0_q <= u0_d; u1_q <= u1_d; u2_q <= u2_d;
      v0_q <= v0_d; v1_q <= v1_d; v2_q <= v2_d;
      w0_q <= w0_d; w1_q <= w1_d; wm1_q <= wm1_d; wm2_q <= wm2_d;
      winf_q <= winf_d;
      r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready is held low while reset is asserted.
  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign Result    = result_q;

endmodule

// File: tb/tb_tc3_mul_seq.sv
module tb_tc3_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] U_IN;
  logic [10:0] V_IN;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] Result;
  logic        busy;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  logic [21:0] exp_q[$];

  tc3_mul_seq #(.LIMB_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .U_IN(U_IN), .V_IN(V_IN),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair, wait (bounded) for acceptance, push expectation.
  task automatic issue(input logic [10:0] u, input logic [10:0] v,
                       input logic [21:0] exp, output int acc_cyc);
    int n;
    n = 0;
    in_valid = 1'b1; U_IN = u; V_IN = v;
    while (!in_ready && n < 50) begin tick(); n++; end
    tests_run++;
    if (!in_ready) begin
      tests_failed++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    exp_q.push_back(exp);
    acc_cyc = cyc;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; U_IN = '0; V_IN = '0;
    #2;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b required 0", busy); end
    tests_run++;
    if (Result !== 22'h0) begin tests_failed++; $display("FAIL rst_result: got %h required 0", Result); end
    #20 rst_n = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_in_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_corners();
    logic [10:0] tu[4] = '{11'h7FF, 11'h000, 11'd1000, 11'h123};
    logic [10:0] tv[4] = '{11'h7FF, 11'h5A5, 11'd3,    11'h456};
    logic [21:0] te[4] = '{22'h3FF001, 22'h0, 22'hBB8, 22'h04EDC2};
    logic [21:0] e;
    int acc;
    for (int i = 0; i < 4; i++) begin
      issue(tu[i], tv[i], te[i], acc);
      wait_valid();
      tests_run++;
      if (cyc - acc != 9) begin tests_failed++; $display("FAIL corner_latency[%0d]: got %0d required 9", i, cyc - acc); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
      tests_run++;
      if (Result !== e) begin tests_failed++; $display("FAIL corner_result[%0d]: got %h required %h", i, Result, e); end
      handshake();
    end
  endtask

  task automatic test_latency_busy();
    int acc, lowb;
    logic [21:0] e;
    lowb = 0;
    issue(11'h123, 11'h456, 22'h04EDC2, acc);
    for (int n = 0; n < 40 && !out_valid; n++) begin
      if (!busy) lowb++;
      tick();
    end
    tests_run++;
    if (cyc - acc != 9) begin tests_failed++; $display("FAIL lat_out_valid_edge: got T+%0d required T+9", cyc - acc); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
    tests_run++;
    if (Result !== e) begin tests_failed++; $display("FAIL lat_result: got %h required %h", Result, e); end
    tests_run++;
    if (lowb != 0 || busy !== 1'b1) begin tests_failed++; $display("FAIL lat_busy: low cycles %0d busy=%0b required 0 and 1", lowb, busy); end
    handshake();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL lat_busy_after: got %0b required 0", busy); end
  endtask

  task automatic test_backpressure();
    int acc, bad;
    logic [21:0] e;
    bad = 0;
    issue(11'd1234, 11'd567, 22'd699678, acc);
    wait_valid();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
    for (int n = 0; n < 20; n++) begin
      if (Result !== e || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL bp_hold: %0d bad cycles required 0 (Result %h exp %h)", bad, Result, e); end
    handshake();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid: got %0b required 0", out_valid); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %0b required 1", in_ready); end
  endtask

  task automatic test_busy_input();
    int acc, extra;
    logic [21:0] e;
    extra = 0;
    issue(11'h6B3, 11'h2C9, 22'(11'h6B3) * 22'(11'h2C9), acc);
    for (int n = 0; n < 7; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      U_IN = 11'($urandom); V_IN = 11'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_valid();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
    tests_run++;
    if (Result !== e) begin tests_failed++; $display("FAIL busy_in_result: got %h required %h", Result, e); end
    handshake();
    for (int n = 0; n < 15; n++) begin
      if (busy || out_valid) extra++;
      tick();
    end
    tests_run++;
    if (extra != 0) begin tests_failed++; $display("FAIL busy_in_extra_op: %0d active cycles required 0", extra); end
  endtask

  task automatic test_reset_mid_eval();
    int acc;
    logic [21:0] e;
    issue(11'h555, 11'h2AA, 22'h0, acc);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_flags: out_valid=%0b busy=%0b required 0 0", out_valid, busy); end
    tests_run++;
    if (Result !== 22'h0) begin tests_failed++; $display("FAIL mid_rst_result: got %h required 0", Result); end
    exp_q.delete();
    #2 rst_n = 1'b1;
    tick();
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_release: in_ready=%0b busy=%0b required 1 0", in_ready, busy); end
    issue(11'd77, 11'd1999, 22'd153923, acc);
    wait_valid();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
    tests_run++;
    if (Result !== e || out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_next_op: got %h valid %0b required %h 1", Result, out_valid, e); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    logic [21:0] e;
    issue(11'h3C3, 11'h0F0, 22'(11'h3C3) * 22'(11'h0F0), acc1);
    wait_valid();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
    tests_run++;
    if (Result !== e) begin tests_failed++; $display("FAIL b2b_first: got %h required %h", Result, e); end
    handshake();
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_after_hs: got %0b required 1", in_ready); end
    issue(11'h0F0, 11'h3C3, 22'(11'h0F0) * 22'(11'h3C3), acc2);
    tests_run++;
    if (acc2 - acc1 != 11) begin tests_failed++; $display("FAIL b2b_interval: got %0d required 11", acc2 - acc1); end
    wait_valid();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
    tests_run++;
    if (Result !== e) begin tests_failed++; $display("FAIL b2b_second: got %h required %h", Result, e); end
    handshake();
  endtask

  task automatic test_regression();
    logic [3:0]  lv[3];
    logic [10:0] u, v;
    logic [21:0] e;
    int acc, d, errs;
    errs = 0;
    for (int i = 0; i < 729 + 2000; i++) begin
      if (i < 729) begin
        d = i;
        for (int j = 0; j < 2; j++) begin
          lv[0] = 4'd0; lv[1] = 4'd1; lv[2] = 4'd15;
          u = '0;
        end
        u = {3'((d % 3 == 2) ? 7 : d % 3), 4'(((d / 3) % 3 == 2) ? 15 : (d / 3) % 3), 4'(((d / 9) % 3 == 2) ? 15 : (d / 9) % 3)};
        d = d / 27;
        v = {3'((d % 3 == 2) ? 7 : d % 3), 4'(((d / 3) % 3 == 2) ? 15 : (d / 3) % 3), 4'(((d / 9) % 3 == 2) ? 15 : (d / 9) % 3)};
      end else begin
        u = 11'($urandom); v = 11'($urandom);
      end
      issue(u, v, 22'(u) * 22'(v), acc);
      out_ready = 1'($urandom_range(0, 1));
      wait_valid();
      out_ready = 1'b0;
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 22'h3FFFFF;
      tests_run++;
      if (Result !== e || out_valid !== 1'b1) begin
        tests_failed++; errs++;
        if (errs < 10) $display("FAIL regr[%0d] u=%h v=%h: got %h valid %0b required %h", i, u, v, Result, out_valid, e);
      end
      handshake();
    end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL regr_queue_left: %0d entries required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_latency_busy();
    test_backpressure();
    test_busy_input();
    test_reset_mid_eval();
    test_back_to_back();
    test_regression();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
